serial_tx_scheduler: RTL and testbench

- Shares one 2-bit serial lane among NUM_REQ byte sources. Each requester offers 8-bit words over a valid/ready handshake.
- Drives the 9-bit {valid, data[7:0]} parallel word that feeds the parallel-to-serial stage. One word is held for each 4-cycle clk16f symbol slot.
- After reset or re-enable, it runs a link-training phase of idle symbols (valid=0, so the serializer emits $BC) before granting any requester.
- Arbitration is round-robin with a bounded burst length.

---
 rtl/serial_tx_scheduler_pkg.sv | 21 ++
 rtl/serial_tx_scheduler_rr_arbiter.sv | 51 +++++
 rtl/serial_tx_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_scheduler_pkg.sv
// Shared definitions for the serial lane scheduler: idle word, slot length, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_tx_scheduler_pkg;

    // {valid, data}: valid=0 makes the serializer send a comma; $BC kept in data for traceability
    localparam logic [8:0] IDLE_WORD = 9'h0BC;
    localparam int         SLOT_LEN  = 4;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        IDLE  = 2'd1,
        SEND  = 2'd2
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int grant_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Round-robin picker: first set bit of req searching upward from start_ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req (request mask), start_ptr, excl_en/excl_idx (drop one requester from the search),
//        grant (one-hot), grant_idx, any_grant.
module serial_tx_scheduler_rr_arbiter
    import serial_tx_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      start_ptr,
    input  logic               excl_en,
    input  logic [GW-1:0]      excl_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_idx,
    output logic               any_grant
);

    localparam int PW = GW + 1;

    logic [NUM_REQ-1:0] mask;
    logic [PW-1:0]      pos;

    always_comb begin
        mask = req;
        if (excl_en) begin
            mask[excl_idx] = 1'b0;
        end
        pos       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // start_ptr + i is below 2*NUM_REQ, so one conditional subtract is a full modulo
            pos = {1'b0, start_ptr} + PW'(i);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!any_grant && mask[pos[GW-1:0]]) begin
                any_grant = 1'b1;
                grant_idx = pos[GW-1:0];
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one 2-bit serial lane among NUM_REQ byte sources; one 9-bit word per 4-cycle slot, link training first.
// Latency: a word taken at a slot boundary (slot_cnt==3) appears on paralelo_out from the next slot_cnt==0.
// Backpressure: req_ready pulses one-hot only at boundaries; a requester not valid there simply loses that slot.
// Ports: clk16f, reset (sync, active-high), link_enable, req_valid/req_data/req_ready (per-requester handshake),
//        paralelo_out {valid,data}, slot_start, grant_id, train_done.
module serial_tx_scheduler
    import serial_tx_scheduler_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int BURST_MAX  = 4,
    parameter  int TRAIN_SYMS = 8,
    localparam int GW         = grant_w(NUM_REQ)
) (
    input  logic                 clk16f,
    input  logic                 reset,
    input  logic                 link_enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [8:0]           paralelo_out,
    output logic                 slot_start,
    output logic [GW-1:0]        grant_id,
    output logic                 train_done
);

    localparam int         PW         = GW + 1;
    localparam logic [1:0] SLOT_LAST  = 2'(SLOT_LEN - 1);
    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_SYMS - 1);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    state_t             state, state_n;
    logic [1:0]         slot_cnt;
    logic [7:0]         train_cnt, train_cnt_n;
    logic [GW-1:0]      rr_ptr, rr_ptr_n;
    logic [3:0]         burst_cnt, burst_cnt_n;
    logic               retrain_pend, retrain_n;
    logic [GW-1:0]      grant_n;
    logic               done_n;
    logic [NUM_REQ-1:0] take_oh;
    logic [7:0]         take_dat;
    logic [NUM_REQ-1:0] cur_oh;
    logic [GW-1:0]      after_g;
    logic               boundary;

    logic [GW-1:0]      arb_start;
    logic               arb_excl;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GW-1:0]      arb_idx;
    logic               arb_any;

    function automatic logic [GW-1:0] ptr_inc(input logic [GW-1:0] p);
        logic [PW-1:0] s;
        s = {1'b0, p} + PW'(1);
        if (s >= PW'(NUM_REQ)) begin
            s = s - PW'(NUM_REQ);
        end
        return s[GW-1:0];
    endfunction

    assign boundary = (slot_cnt == SLOT_LAST);
    assign after_g  = ptr_inc(grant_id);

    always_comb begin
        cur_oh           = '0;
        cur_oh[grant_id] = 1'b1;
    end

    // Leaving a burst searches from the owner's successor; the owner is only eligible again
    // when nobody else is asking, which keeps a lone requester streaming without a gap.
    assign arb_start = (state == SEND) ? after_g : rr_ptr;
    assign arb_excl  = (state == SEND) && |(req_valid & ~cur_oh);

    serial_tx_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .start_ptr (arb_start),
        .excl_en   (arb_excl),
        .excl_idx  (grant_id),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // State and datapath registers
    always_ff @(posedge clk16f) begin
        if (reset) begin
            slot_cnt     <= 2'd0;
            state        <= TRAIN;
            train_cnt    <= 8'd0;
            rr_ptr       <= '0;
            burst_cnt    <= 4'd0;
            retrain_pend <= 1'b0;
            paralelo_out <= IDLE_WORD;
            grant_id     <= '0;
            train_done   <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 2'd1;
            if (boundary) begin
                state        <= state_n;
                train_cnt    <= train_cnt_n;
                rr_ptr       <= rr_ptr_n;
                burst_cnt    <= burst_cnt_n;
                retrain_pend <= retrain_n;
                grant_id     <= grant_n;
                train_done   <= done_n;
                paralelo_out <= (|take_oh) ? {1'b1, take_dat} : IDLE_WORD;
            end
        end
    end

    // Next-state and word selection; only meaningful at a boundary
    always_comb begin
        state_n     = state;
        train_cnt_n = train_cnt;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        retrain_n   = retrain_pend;
        grant_n     = grant_id;
        done_n      = train_done;
        take_oh     = '0;
        if (boundary) begin
            case (state)
                TRAIN: begin
                    // Last training slot: arbitrate at this boundary so the first data slot
                    // follows the final idle slot directly.
                    if (train_cnt == TRAIN_LAST) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        if (link_enable && arb_any) begin
                            take_oh     = arb_grant;
                            grant_n     = arb_idx;
                            burst_cnt_n = 4'd1;
                            state_n     = SEND;
                        end
                    end else begin
                        train_cnt_n = train_cnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (!link_enable) begin
                        retrain_n = 1'b1;
                    end else if (retrain_pend) begin
                        state_n     = TRAIN;
                        train_cnt_n = 8'd0;
                        done_n      = 1'b0;
                        retrain_n   = 1'b0;
                    end else if (arb_any) begin
                        take_oh     = arb_grant;
                        grant_n     = arb_idx;
                        burst_cnt_n = 4'd1;
                        state_n     = SEND;
                    end
                end
                SEND: begin
                    if (!link_enable) begin
                        rr_ptr_n  = after_g;
                        state_n   = IDLE;
                        retrain_n = 1'b1;
                    end else if (req_valid[grant_id] && (burst_cnt < BURST_LIM)) begin
                        take_oh     = cur_oh;
                        burst_cnt_n = burst_cnt + 4'd1;
                    end else begin
                        rr_ptr_n = after_g;
                        if (arb_any) begin
                            take_oh     = arb_grant;
                            grant_n     = arb_idx;
                            burst_cnt_n = 4'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = TRAIN;
            endcase
        end
    end

    // Outputs: ready pulse is combinational so it tracks req_valid in the boundary cycle itself
    always_comb begin
        req_ready  = reset ? '0 : take_oh;
        slot_start = (slot_cnt == 2'd0);
        take_dat   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take_oh[i]) begin
                take_dat = take_dat | req_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
module tb_serial_tx_scheduler;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int TS = 8;

    logic           clk16f = 1'b0;
    logic           reset = 1'b0;
    logic           link_enable = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [8:0]     paralelo_out;
    logic           slot_start;
    logic [1:0]     grant_id;
    logic           train_done;

    always #5 clk16f = ~clk16f;

    serial_tx_scheduler #(.NUM_REQ(N), .BURST_MAX(BM), .TRAIN_SYMS(TS)) dut (
        .clk16f       (clk16f),
        .reset        (reset),
        .link_enable  (link_enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .paralelo_out (paralelo_out),
        .slot_start   (slot_start),
        .grant_id     (grant_id),
        .train_done   (train_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slot-level behavioural model ----------------
    // m_train: idle slots still owed before requesters may be served (0 = linked)
    // m_owner: requester holding the lane (-1 = nobody), m_run: words in its current burst
    bit         m_ok = 1'b0;
    int         m_slot, m_train, m_owner, m_run, m_ptr, m_gid;
    bit         m_lost, m_done;
    logic [8:0] m_word;

    int         p_take, p_train, p_owner, p_run, p_ptr, p_gid;
    bit         p_lost, p_done;
    logic [8:0] p_word;

    function automatic int first_valid(input int from);
        for (int k = 0; k < N; k++) begin
            if (req_valid[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic take(input int idx);
        p_take  = idx;
        p_gid   = idx;
        p_word  = {1'b1, req_data[8*idx +: 8]};
    endtask

    // What the next boundary does, given the model state and the current inputs
    task automatic plan();
        int w;
        p_take  = -1;
        p_train = m_train;
        p_owner = m_owner;
        p_run   = m_run;
        p_ptr   = m_ptr;
        p_gid   = m_gid;
        p_lost  = m_lost;
        p_done  = m_done;
        p_word  = 9'h0BC;
        if (m_train > 0) begin
            p_train = m_train - 1;
            if (p_train == 0) begin
                p_done = 1'b1;
                w = first_valid(m_ptr);
                if (link_enable && w >= 0) begin
                    take(w);
                    p_owner = w;
                    p_run   = 1;
                end
            end
        end else if (!link_enable) begin
            p_lost = 1'b1;
            if (m_owner >= 0) p_ptr = (m_owner + 1) % N;
            p_owner = -1;
        end else if (m_lost) begin
            p_lost  = 1'b0;
            p_train = TS;
            p_done  = 1'b0;
        end else if (m_owner >= 0 && req_valid[m_owner] && m_run < BM) begin
            take(m_owner);
            p_run = m_run + 1;
        end else begin
            // searching from the owner's successor reaches the owner itself last
            if (m_owner >= 0) p_ptr = (m_owner + 1) % N;
            w = first_valid(p_ptr);
            if (w >= 0) begin
                take(w);
                p_owner = w;
                p_run   = 1;
            end else begin
                p_owner = -1;
            end
        end
    endtask

    always @(posedge clk16f) begin
        if (reset) begin
            m_ok    = 1'b1;
            m_slot  = 0;
            m_train = TS;
            m_owner = -1;
            m_run   = 0;
            m_ptr   = 0;
            m_gid   = 0;
            m_lost  = 1'b0;
            m_done  = 1'b0;
            m_word  = 9'h0BC;
        end else if (m_ok) begin
            if (m_slot == 3) begin
                plan();
                m_train = p_train;
                m_owner = p_owner;
                m_run   = p_run;
                m_ptr   = p_ptr;
                m_gid   = p_gid;
                m_lost  = p_lost;
                m_done  = p_done;
                m_word  = p_word;
            end
            m_slot = (m_slot + 1) % 4;
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle
    always @(negedge clk16f) begin
        logic [N-1:0] exp_rdy;
        if (m_ok) begin
            plan();
            exp_rdy = '0;
            if (m_slot == 3 && !reset && p_take >= 0) exp_rdy[p_take] = 1'b1;
            check("model paralelo_out", 32'(paralelo_out), 32'(m_word));
            check("model req_ready",    32'(req_ready),    32'(exp_rdy));
            check("model grant_id",     32'(grant_id),     32'(m_gid));
            check("model train_done",   32'(train_done),   32'(m_done));
            check("model slot_start",   32'(slot_start),   32'(m_slot == 0));
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic tick();
        @(posedge clk16f);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Leaves the bench in cycle 0 of slot 1 after reset
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int exp_g[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int idle_cnt;
    int low_cnt;

    initial begin
        // 1: training length, then requester 0 streams A5
        link_enable = 1'b1;
        req_data    = {8'h44, 8'h33, 8'h22, 8'hA5};
        req_valid   = 4'b0001;
        do_reset();
        check("reset paralelo_out", 32'(paralelo_out), 32'h0BC);
        check("reset req_ready",    32'(req_ready),    32'h0);
        check("reset grant_id",     32'(grant_id),     32'h0);
        check("reset train_done",   32'(train_done),   32'h0);
        check("reset slot_start",   32'(slot_start),   32'h1);
        idle_cnt = 0;
        for (int s = 1; s <= TS; s++) begin
            if (paralelo_out == 9'h0BC) idle_cnt++;
            ticks(4);
        end
        check("train idle slots",   32'(idle_cnt),     32'd8);
        check("first data word",    32'(paralelo_out), 32'h1A5);
        check("train_done after",   32'(train_done),   32'h1);

        // 2: all four valid -> bursts of four, no gap between them
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        do_reset();
        ticks(4 * TS);
        for (int s = 0; s < 17; s++) begin
            check("rr grant order", 32'(grant_id),        32'(exp_g[s]));
            check("rr no bubble",   32'(paralelo_out[8]), 32'h1);
            ticks(4);
        end

        // 3: only requester 2 -> re-granted after its burst with no idle slot
        req_valid = 4'b0100;
        do_reset();
        ticks(4 * TS);
        for (int s = 0; s < 9; s++) begin
            check("lone requester word", 32'(paralelo_out), 32'h133);
            ticks(4);
        end

        // 4: requester 1 drops after two words, requester 3 takes over
        req_valid = 4'b1010;
        do_reset();
        ticks(4 * TS);
        check("drop first grant", 32'(grant_id),     32'd1);
        check("drop first word",  32'(paralelo_out), 32'h122);
        ticks(4);
        req_valid = 4'b1000;
        ticks(4);
        check("drop next grant",  32'(grant_id),     32'd3);
        check("drop next word",   32'(paralelo_out), 32'h144);
        ticks(8);

        // 5: link_enable low for 6 cycles across a boundary during SEND -> idle, then retrain
        req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
        req_valid = 4'b0001;
        do_reset();
        ticks(4 * (TS + 1));
        check("pre-drop word", 32'(paralelo_out), 32'h1A5);
        link_enable = 1'b0;
        ticks(6);
        link_enable = 1'b1;
        check("link-low idle", 32'(paralelo_out), 32'h0BC);
        ticks(2);
        idle_cnt = 0;
        low_cnt  = 0;
        for (int s = 0; s < TS; s++) begin
            if (paralelo_out == 9'h0BC) idle_cnt++;
            if (!train_done) low_cnt++;
            ticks(4);
        end
        check("retrain idle slots",    32'(idle_cnt),     32'd8);
        check("retrain done low",      32'(low_cnt),      32'd8);
        check("post-retrain word",     32'(paralelo_out), 32'h1A5);
        check("post-retrain done",     32'(train_done),   32'h1);

        // 6: reset at slot_cnt==2 during SEND
        ticks(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset paralelo_out", 32'(paralelo_out), 32'h0BC);
        check("mid reset req_ready",    32'(req_ready),    32'h0);
        check("mid reset slot_start",   32'(slot_start),   32'h1);
        check("mid reset train_done",   32'(train_done),   32'h0);
        ticks(4 * TS);
        check("after mid reset word",   32'(paralelo_out), 32'h1A5);
        // reset held on a boundary cycle: no word may be taken
        ticks(3);
        reset = 1'b1;
        #1;
        check("reset boundary ready",   32'(req_ready),    32'h0);
        tick();
        reset = 1'b0;
        ticks(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
